// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 registers and range-checks a decoded request,
// stage 2 packs the 32-bit word and holds it under backpressure.
module inst_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic                 s1_valid_q;
    logic [2:0]           s1_fmt_q;
    logic [6:0]           s1_op_q;
    logic [4:0]           s1_rd_q;
    logic [4:0]           s1_rs1_q;
    logic [4:0]           s1_rs2_q;
    logic [2:0]           s1_f3_q;
    logic [6:0]           s1_f7_q;
    logic [31:0]          s1_imm_q;
    logic                 s1_err_q;
    logic                 out_valid_q;
    logic [31:0]          out_inst_q;
    logic                 out_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic                 s1_adv;
    logic                 in_err;
    logic [31:0]          pack_d;
    logic signed [31:0]   imm_s;

    assign imm_s    = in_imm;
    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !reset && (!s1_valid_q || s1_adv);

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

    always_comb begin
        in_err = 1'b0;
        case (in_fmt)
            FmtR:       in_err = 1'b0;
            FmtI, FmtS: in_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FmtB:       in_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            FmtU:       in_err = |in_imm[11:0];
            FmtJ:       in_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            default:    in_err = 1'b1;
        endcase
    end

    always_comb begin
        pack_d = Nop;
        if (!s1_err_q) begin
            case (s1_fmt_q)
                FmtR: pack_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                FmtI: pack_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
                FmtS: pack_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                                s1_op_q};
                FmtB: pack_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
                FmtU: pack_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
                FmtJ: pack_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                s1_rd_q, s1_op_q};
                default: pack_d = Nop;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_op_q     <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_f3_q     <= '0;
            s1_f7_q     <= '0;
            s1_imm_q    <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            // in_ready implies stage 1 is empty or draining, so it simply takes in_valid
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_fmt_q <= in_fmt;
                    s1_op_q  <= in_opcode;
                    s1_rd_q  <= in_rd;
                    s1_rs1_q <= in_rs1;
                    s1_rs2_q <= in_rs2;
                    s1_f3_q  <= in_funct3;
                    s1_f7_q  <= in_funct7;
                    s1_imm_q <= in_imm;
                    s1_err_q <= in_err;
                end
            end
            if (s1_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q <= pack_d;
                    out_err_q  <= s1_err_q;
                end
            end
            if (out_valid_q && out_ready && out_err_q && (err_count_q != '1)) begin
                err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
        end
    end

endmodule
